// File: rtl/soc_bus_router.sv
// Single-outstanding bus router: round-robin arbitration of masters, address decode
// onto target ports, and a response timeout that turns stalled transfers into errors.
//
// state | meaning
// IDLE  | arbitrate; grant and latch the winning request
// REQ   | drive the selected target until it grants
// RESP  | wait for the selected target's response
// ERR   | one-cycle error response to the winning master
module soc_bus_router #(
   parameter int NB_MASTER  = 3,
   parameter int NB_REGION  = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [NB_REGION*ADDR_WIDTH-1:0] START_ADDR =
      {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
   parameter logic [NB_REGION*ADDR_WIDTH-1:0] END_ADDR =
      {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF},
   parameter int TIMEOUT    = 255
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NB_MASTER-1:0]              m_req_i,
   input  logic [NB_MASTER*ADDR_WIDTH-1:0]   m_addr_i,
   input  logic [NB_MASTER-1:0]              m_we_i,
   input  logic [NB_MASTER*DATA_WIDTH/8-1:0] m_be_i,
   input  logic [NB_MASTER*DATA_WIDTH-1:0]   m_wdata_i,
   output logic [NB_MASTER-1:0]              m_gnt_o,
   output logic [NB_MASTER-1:0]              m_rvalid_o,
   output logic [DATA_WIDTH-1:0]             m_rdata_o,
   output logic                              m_err_o,
   output logic [NB_REGION-1:0]              s_req_o,
   output logic [ADDR_WIDTH-1:0]             s_addr_o,
   output logic                              s_we_o,
   output logic [DATA_WIDTH/8-1:0]           s_be_o,
   output logic [DATA_WIDTH-1:0]             s_wdata_o,
   input  logic [NB_REGION-1:0]              s_gnt_i,
   input  logic [NB_REGION-1:0]              s_rvalid_i,
   input  logic [NB_REGION*DATA_WIDTH-1:0]   s_rdata_i
);
   localparam int MW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
   localparam int RW = (NB_REGION > 1) ? $clog2(NB_REGION) : 1;
   localparam int BW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

   state_t                state;
   logic [MW-1:0]         rr_ptr, win_q, gnt_idx;
   logic [RW-1:0]         sel_q, hit_idx;
   logic                  gnt_any, hit, tout;
   logic [ADDR_WIDTH-1:0] addr_q, gnt_addr;
   logic                  we_q;
   logic [BW-1:0]         be_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [15:0]           tcnt;

   always_comb begin : arb
      int idx;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < NB_MASTER; k++) begin
         idx = (int'(rr_ptr) + k) % NB_MASTER;
         if (!gnt_any && m_req_i[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = MW'(idx);
         end
      end
   end

   assign gnt_addr = m_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];

   // Scan from the top so the lowest-indexed matching region wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int r = NB_REGION - 1; r >= 0; r--) begin
         if (gnt_addr >= START_ADDR[r*ADDR_WIDTH +: ADDR_WIDTH] &&
             gnt_addr <= END_ADDR[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit     = 1'b1;
            hit_idx = RW'(r);
         end
      end
   end

   // tcnt counts completed REQ/RESP cycles, so the current cycle is number tcnt+1.
   assign tout = (17'(tcnt) + 17'd1) >= 17'(TIMEOUT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         win_q   <= '0;
         sel_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         tcnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  win_q   <= gnt_idx;
                  sel_q   <= hit_idx;
                  addr_q  <= gnt_addr;
                  we_q    <= m_we_i[gnt_idx];
                  be_q    <= m_be_i[gnt_idx*BW +: BW];
                  wdata_q <= m_wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                  rr_ptr  <= (gnt_idx == MW'(NB_MASTER - 1)) ? '0 : gnt_idx + MW'(1);
                  tcnt    <= '0;
                  state   <= hit ? REQ : ERR;
               end
            end
            REQ: begin
               tcnt <= tcnt + 16'd1;
               if (s_gnt_i[sel_q])
                  state <= RESP;
               else if (tout)
                  state <= ERR;
            end
            RESP: begin
               tcnt <= tcnt + 16'd1;
               if (s_rvalid_i[sel_q])
                  state <= IDLE;
               else if (tout)
                  state <= ERR;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      m_rdata_o  = '0;
      m_err_o    = 1'b0;
      s_req_o    = '0;
      s_addr_o   = '0;
      s_we_o     = 1'b0;
      s_be_o     = '0;
      s_wdata_o  = '0;
      if (!rst) begin
         case (state)
            IDLE: m_gnt_o[gnt_idx] = gnt_any;
            REQ: begin
               s_req_o[sel_q] = 1'b1;
               s_addr_o       = addr_q;
               s_we_o         = we_q;
               s_be_o         = be_q;
               s_wdata_o      = wdata_q;
            end
            RESP: begin
               if (s_rvalid_i[sel_q]) begin
                  m_rvalid_o[win_q] = 1'b1;
                  m_rdata_o         = s_rdata_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
               end
            end
            default: begin
               m_rvalid_o[win_q] = 1'b1;
               m_err_o           = 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_soc_bus_router.sv
// Randomized bench for soc_bus_router: each transaction's outcome and timing is predicted
// from the arbitration, decode and timeout rules, then checked cycle by cycle.
module tb_soc_bus_router;
   localparam int NM = 3;
   localparam int NR = 3;
   localparam int T  = 4;
   localparam int NEVER = 1000;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    m_req_i, m_we_i;
   logic [95:0]   m_addr_i, m_wdata_i;
   logic [11:0]   m_be_i;
   logic [2:0]    m_gnt_o, m_rvalid_o;
   logic [31:0]   m_rdata_o;
   logic          m_err_o;
   logic [2:0]    s_req_o;
   logic [31:0]   s_addr_o;
   logic          s_we_o;
   logic [3:0]    s_be_o;
   logic [31:0]   s_wdata_o;
   logic [2:0]    s_gnt_i, s_rvalid_i;
   logic [95:0]   s_rdata_i;

   soc_bus_router #(.TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
      .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
      .m_rdata_o(m_rdata_o), .m_err_o(m_err_o), .s_req_o(s_req_o), .s_addr_o(s_addr_o),
      .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i),
      .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [31:0] rs[NR] = '{32'h0000_0000, 32'h0010_0000, 32'h1A10_0000};
   logic [31:0] re[NR] = '{32'h000F_FFFF, 32'h001F_FFFF, 32'h1A11_FFFF};

   int          rr = 0;
   logic [2:0]  tx_mask;
   logic [31:0] tx_addr[NM];
   int          tx_g, tx_r;
   logic [31:0] tx_rdata;

   function automatic int decode(input logic [31:0] a);
      for (int r = 0; r < NR; r++)
         if (a >= rs[r] && a <= re[r]) return r;
      return -1;
   endfunction

   function automatic logic [31:0] pick_addr();
      int k;
      k = $urandom_range(0, NR - 1);
      case ($urandom_range(0, 5))
         0: return rs[k];
         1: return re[k];
         2: return rs[k] + ($urandom % (re[k] - rs[k] + 32'd1));
         3: return re[k] + 32'd1;
         4: return rs[k] - 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic scramble_masters();
      m_addr_i  = {$urandom, $urandom, $urandom};
      m_wdata_i = {$urandom, $urandom, $urandom};
      m_we_i    = 3'($urandom);
      m_be_i    = 12'($urandom);
   endtask

   // Called just after a rising edge with the DUT in IDLE; returns after the last cycle.
   task automatic run_txn();
      int w, reg_i, req_end, e, c0;
      bit is_err, in_req;
      logic [2:0] sm;
      logic [31:0] a_exp;
      logic [36:0] wr_exp;
      w = -1;
      for (int k = 0; k < NM; k++)
         if (w < 0 && tx_mask[(rr + k) % NM]) w = (rr + k) % NM;
      scramble_masters();
      m_req_i = tx_mask;
      for (int i = 0; i < NM; i++) m_addr_i[i*32 +: 32] = tx_addr[i];
      s_gnt_i    = 3'($urandom);
      s_rvalid_i = 3'($urandom);
      s_rdata_i  = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk("gnt", {61'd0, m_gnt_o}, (w < 0) ? 64'd0 : 64'd1 << w);
      if (w < 0) return;
      a_exp  = tx_addr[w];
      wr_exp = {m_we_i[w], m_be_i[w*4 +: 4], m_wdata_i[w*32 +: 32]};
      rr     = (w + 1) % NM;
      reg_i  = decode(tx_addr[w]);
      is_err = 1'b1;
      if (reg_i < 0) begin
         req_end = 0; e = 1;
      end else if (tx_g > T) begin
         req_end = T; e = T + 1;
      end else begin
         req_end = tx_g;
         c0 = (tx_g + 1 > T) ? tx_g + 1 : T;
         if (tx_r <= c0) begin e = tx_r; is_err = 1'b0; end
         else e = c0 + 1;
      end
      sm = (reg_i < 0) ? 3'b000 : 3'(1 << reg_i);
      for (int c = 1; c <= e; c++) begin
         @(posedge clk); #1;
         scramble_masters();
         s_gnt_i    = (3'($urandom) & ~sm) | ((c == tx_g) ? sm : 3'b000);
         s_rvalid_i = (3'($urandom) & ~sm) | ((c == tx_r) ? sm : 3'b000);
         s_rdata_i  = {$urandom, $urandom, $urandom};
         if (reg_i >= 0) s_rdata_i[reg_i*32 +: 32] = tx_rdata;
         @(negedge clk);
         in_req = (reg_i >= 0) && (c <= req_end);
         chk("s_req", {61'd0, s_req_o}, in_req ? {61'd0, sm} : 64'd0);
         chk("s_addr", {32'd0, s_addr_o}, in_req ? {32'd0, a_exp} : 64'd0);
         chk("s_wr", {27'd0, s_we_o, s_be_o, s_wdata_o}, in_req ? {27'd0, wr_exp} : 64'd0);
         chk("busy_gnt", {61'd0, m_gnt_o}, 64'd0);
         chk("rvalid", {61'd0, m_rvalid_o}, (c == e) ? 64'd1 << w : 64'd0);
         chk("err", {63'd0, m_err_o}, (c == e && is_err) ? 64'd1 : 64'd0);
         chk("rdata", {32'd0, m_rdata_o}, (c == e && !is_err) ? {32'd0, tx_rdata} : 64'd0);
      end
   endtask

   task automatic next_txn();
      @(posedge clk); #1;
      run_txn();
   endtask

   task automatic set_txn(input logic [2:0] mask, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input int g, input int r, input logic [31:0] rd);
      tx_mask = mask;
      tx_addr[0] = a0; tx_addr[1] = a1; tx_addr[2] = a2;
      tx_g = g; tx_r = r; tx_rdata = rd;
   endtask

   initial begin
      rst = 1'b1;
      m_req_i = 3'b111;
      scramble_masters();
      s_gnt_i = 3'b111; s_rvalid_i = 3'b111; s_rdata_i = {$urandom, $urandom, $urandom};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m", {25'd0, m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o}, 64'd0);
      chk("rst_s", {23'd0, s_req_o, s_we_o, s_be_o, s_addr_o}, 64'd0);
      chk("rst_wd", {32'd0, s_wdata_o}, 64'd0);

      // Continuous requests from all masters rotate 0,1,2,0; release reset straight into a grant.
      @(posedge clk); #1;
      rst = 1'b0;
      set_txn(3'b111, 32'h0000_0100, 32'h0010_0040, 32'h1A10_0000, 1, 2, 32'h1111_0000);
      run_txn();
      for (int i = 0; i < 3; i++) begin
         tx_rdata = $urandom;
         next_txn();
      end
      set_txn(3'b010, 32'h0, 32'h0010_0040, 32'h0, 1, 2, 32'hCAFE_F00D);
      next_txn();
      set_txn(3'b001, 32'h0800_0000, 32'h0, 32'h0, 1, 2, 32'h0);
      next_txn();
      set_txn(3'b100, 32'h0, 32'h0, 32'h1A11_0000, NEVER, NEVER, 32'h0);
      next_txn();
      set_txn(3'b100, 32'h0, 32'h0, 32'h1A11_FFFF, 1, NEVER, 32'h0);
      next_txn();
      set_txn(3'b011, 32'h000F_FFFF, 32'h001F_FFFF, 32'h0, 1, T, 32'h2222_3333);
      next_txn();
      set_txn(3'b011, 32'h000F_FFFF, 32'h001F_FFFF, 32'h0, T, T + 1, 32'h4444_5555);
      next_txn();
      set_txn(3'b001, 32'h0, 32'h0, 32'h0, T + 1, T + 2, 32'h6666_7777);
      next_txn();

      for (int n = 0; n < 120; n++) begin
         tx_mask = 3'($urandom_range(0, 7));
         for (int i = 0; i < NM; i++) tx_addr[i] = pick_addr();
         tx_g = $urandom_range(1, 6);
         tx_r = tx_g + $urandom_range(1, 3);
         tx_rdata = $urandom;
         next_txn();
      end

      // Reset while target 2 owes a response: nothing may come back afterwards.
      @(posedge clk); #1;
      m_req_i = 3'b001; m_addr_i[31:0] = 32'h1A10_0100;
      s_gnt_i = 3'b000; s_rvalid_i = 3'b000;
      @(negedge clk);
      chk("r30_gnt", {61'd0, m_gnt_o}, 64'd1);
      @(posedge clk); #1;
      s_gnt_i = 3'b100;
      @(negedge clk);
      chk("r30_sreq", {61'd0, s_req_o}, 64'd4);
      @(posedge clk); #1;
      s_gnt_i = 3'b000; m_req_i = 3'b000; rst = 1'b1;
      @(negedge clk);
      chk("r30_rst", {25'd0, m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; s_rvalid_i = 3'b100;
      @(negedge clk);
      chk("r30_rv", {58'd0, m_rvalid_o, s_req_o}, 64'd0);
      rr = 0;
      set_txn(3'b110, 32'h0, 32'h0010_0000, 32'h1A10_0000, 2, 3, 32'h8888_9999);
      next_txn();
      set_txn(3'b111, 32'h0000_0000, 32'h0, 32'h0, 1, 2, 32'hAAAA_BBBB);
      next_txn();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/soc_bus_router.md
SOC_BUS_ROUTER -- requirements
Module: soc_bus_router

Interface
REQ-001 SHALL have parameter NB_MASTER, default 3: number of requesting ports, range 1..8.
REQ-002 SHALL have parameter NB_REGION, default 3: number of address-mapped target ports, range 1..8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: data width, a multiple of 8.
REQ-005 SHALL have parameter START_ADDR, default {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000}: packed NB_REGION x ADDR_WIDTH, inclusive region base, index 0 in the LSBs.
REQ-006 SHALL have parameter END_ADDR, default {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF}: packed NB_REGION x ADDR_WIDTH, inclusive region end.
REQ-007 SHALL have parameter TIMEOUT, default 255: maximum cycles from leaving IDLE to target response, range 1..65535.
REQ-008 SHALL have the following ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state updates on the rising edge.
  rst  in  1  synchronous, active-high reset.
  m_req_i  in  NB_MASTER  per-master request.
  m_addr_i  in  NB_MASTER x ADDR_WIDTH  per-master address.
  m_we_i  in  NB_MASTER  per-master write enable.
  m_be_i  in  NB_MASTER x DATA_WIDTH/8  per-master byte enables.
  m_wdata_i  in  NB_MASTER x DATA_WIDTH  per-master write data.
  m_gnt_o  out  NB_MASTER  one-hot grant; request accepted.
  m_rvalid_o  out  NB_MASTER  one-hot response valid.
  m_rdata_o  out  DATA_WIDTH  response data, shared by all masters.
  m_err_o  out  1  response is an error; qualified by m_rvalid_o.
  s_req_o  out  NB_REGION  one-hot target request.
  s_addr_o  out  ADDR_WIDTH  target address, shared by all targets.
  s_we_o  out  1  target write enable.
  s_be_o  out  DATA_WIDTH/8  target byte enables.
  s_wdata_o  out  DATA_WIDTH  target write data.
  s_gnt_i  in  NB_REGION  target accepted the request.
  s_rvalid_i  in  NB_REGION  target response valid.
  s_rdata_i  in  NB_REGION x DATA_WIDTH  target response data.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, RESP and ERR, with one transaction outstanding at a time.
REQ-010 In IDLE with any m_req_i set, SHALL combinationally assert m_gnt_o for one master only, chosen round-robin starting from index rr_ptr.
REQ-011 On the grant cycle, SHALL latch the winner index, address, we, be and wdata, and set rr_ptr to (winner+1) mod NB_MASTER.
REQ-012 On the grant cycle, SHALL decode the address against all regions (START <= addr <= END); overlapping regions resolve to the lowest index.
REQ-013 After the grant cycle, SHALL go to REQ on a decode hit and to ERR on a miss.
REQ-014 In REQ, SHALL drive s_req_o[sel] high and s_addr/we/be/wdata from the latched values, holding them stable until s_gnt_i[sel] is high; then go to RESP.
REQ-015 In RESP, on s_rvalid_i[sel], SHALL in the same cycle drive m_rvalid_o[winner]=1, m_rdata_o=s_rdata_i[sel], m_err_o=0, then go to IDLE.
REQ-016 In ERR, SHALL drive m_rvalid_o[winner]=1, m_err_o=1, m_rdata_o=0 for exactly one cycle, then go to IDLE.
REQ-017 SHALL provide a 16-bit timeout counter, cleared on the grant cycle and incremented each cycle in REQ and in RESP.
REQ-018 When the counter equals TIMEOUT with no s_gnt_i (REQ) or no s_rvalid_i (RESP) in that cycle, SHALL go to ERR, dropping s_req_o.
REQ-019 A response arriving in the same cycle as the timeout SHALL take priority over the timeout.
REQ-020 SHALL ignore s_rvalid_i and s_gnt_i from non-selected targets, and in IDLE and ERR.
REQ-021 SHALL assert no m_gnt_o in REQ, RESP or ERR; a master requesting in its own response cycle is arbitrated in the next IDLE cycle.
REQ-022 Minimum latency SHALL be: grant cycle 0, s_req_o cycle 1, m_rvalid_o cycle 2 when the target grants at cycle 1 and responds at cycle 2.
REQ-023 Outputs not otherwise driven in a state SHALL be 0.

Reset
REQ-024 While rst=1 at a clock edge, SHALL set state=IDLE, rr_ptr=0, timeout counter=0 and latched fields=0, and hold all outputs at 0, including mid-transaction; no response is issued for an aborted transfer.
REQ-025 The first cycle after reset deasserts SHALL be able to grant.

Verification
REQ-026 Masters 0,1,2 request simultaneously and continuously after reset -> grants in order 0,1,2,0, each followed by its response.
REQ-027 Master 1 reads 32'h0010_0040; target 1 grants at cycle 1 and returns rdata 32'hCAFE_F00D at cycle 2 -> m_rvalid_o=3'b010, m_rdata_o=32'hCAFE_F00D, m_err_o=0 at cycle 2.
REQ-028 Master 0 writes 32'h0800_0000 (unmapped) -> s_req_o stays 0; m_rvalid_o[0]=1 with m_err_o=1 exactly one cycle after the grant.
REQ-029 TIMEOUT=4, target never responds -> s_req_o drops and m_err_o=1 with m_rvalid_o set, 5 cycles after the grant.
REQ-030 rst asserted in RESP while target 2 is pending -> the next cycle is IDLE with all outputs 0; a later s_rvalid_i[2] produces no m_rvalid_o.
